serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Downstream consumer of the 8-bit universal shift register's serial output (`serial_out_R`, LSB-first right shifts).
- Detects framed serial words and assembles them into parallel bytes: start bit, DATA_W data bits, optional parity bit, stop bit.
- Delivers each good byte through a single-entry valid/ready output register.
- Flags parity, framing and overrun errors.
- The shift strobe (the shift register's clock-enable in shift-right mode) is fed in as `bit_en`, so one bit is sampled per strobe.

Parameters:
- DATA_W, 8: data bits per frame.
- PARITY_EN, 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- serial_in, input, 1: serial line; idle level 1; sampled only when bit_en=1.
- bit_en, input, 1: bit strobe; each high cycle presents one line bit.
- data_out, output, DATA_W: received byte; bit 0 is the first data bit received.
- data_valid, output, 1: data_out holds an unconsumed byte.
- data_ready, input, 1: consumer accepts data_out when data_valid&&data_ready.
- parity_err, output, 1: 1-cycle pulse; frame dropped on parity mismatch.
- frame_err, output, 1: 1-cycle pulse; frame dropped because stop bit sampled 0.
- overrun, output, 1: 1-cycle pulse; good frame dropped because output register was full.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE, bit counter to 0, shift buffer to 0.
  - data_out=0; data_valid, parity_err, frame_err, overrun, busy all 0.
  - Reset wins over every simultaneous event, including mid-frame. A partial frame is discarded.
- bit_en=0: no state, counter or shift buffer change. Output handshake still operates.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on bit_en && serial_in==0 (start bit), go to DATA with cnt=0. A 1 on the line keeps IDLE.
  - DATA: on bit_en, buf <= {serial_in, buf[DATA_W-1:1]}; cnt++. After the DATA_W-th bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on bit_en, latch the parity bit and go to STOP. Expected bit is ^buf for even, ~^buf for odd.
  - STOP: on bit_en, resolve the frame and go to IDLE. A start bit can begin on the very next bit_en.
- Frame resolution, in the cycle after the stop-bit edge, in priority order:
  1. Stop bit 0: frame_err pulses for 1 cycle; byte discarded.
  2. Else parity mismatch (PARITY_EN=1): parity_err pulses; byte discarded.
  3. Else good byte:
     - If !data_valid || data_ready: data_out <= buf and data_valid=1.
     - Otherwise overrun pulses; the held byte is kept and the new byte is lost.
- Latency: data_valid rises 1 clk after the clk edge where the stop bit is sampled.
- Handshake:
  - data_out and data_valid are stable while data_valid && !data_ready.
  - Accept with no load clears data_valid next cycle.
  - Accept and good-byte load in the same cycle: new byte is loaded and data_valid stays 1, with no bubble and no overrun.
- Error pulses never assert together. data_valid is unaffected by errored frames.

Test Plan:
- Basic receive: rst for 2 cycles, then bit_en every 4th cycle, PARITY_EN=1 even. Line: start 0; data 1,0,1,0,0,1,0,1; parity 0; stop 1.
  -> data_out=8'hA5, data_valid=1 one clk after the stop edge; no error pulses. Hold data_ready=0 for 5 cycles and check A5 is stable; then data_ready=1 -> data_valid=0 next cycle.
- Parity error: same frame with parity bit 1 -> parity_err pulses exactly 1 cycle; data_valid stays 0; busy=0 afterwards.
- Framing error: 0x3C frame, correct parity, stop bit 0 -> frame_err 1-cycle pulse; no data_valid. The next frame 0x81 is received correctly.
- Back-to-back and overrun:
  - Frame 0x11 then 0x22 with data_ready=0 -> data_out stays 0x11; overrun pulses at the second stop.
  - Repeat with data_ready=1 on the 0x22 load cycle -> data_out=0x22; data_valid continuous; no overrun.
- Reset mid-frame: assert rst after 4 data bits of 0xF0 -> all outputs 0, busy=0. A subsequent frame 0x5A is received cleanly with no residue from the aborted frame.
- Strobe gating: frame 0xC3 with irregular bit_en gaps (1-7 cycles) and serial_in toggling while bit_en=0 -> data_out=0xC3, proving sampling only on bit_en.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial word receiver with parity/framing/overrun
// detection and a single-entry valid/ready output register.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_bad_q, par_bad_d;
  logic              stop_bad_q, stop_bad_d;
  logic              resolve_q, resolve_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic par_exp;
  logic good;
  logic accept;
  logic load;

  // Expected parity bit for the byte currently in the shift buffer.
  assign par_exp = PARITY_ODD ? ~(^shreg_q) : (^shreg_q);

  // Frame resolution runs one cycle after the stop bit is sampled.
  assign good   = resolve_q && !stop_bad_q && !par_bad_q;
  assign accept = valid_q && data_ready;
  assign load   = good && (!valid_q || data_ready);

  // Next-state logic for the bit FSM, the resolver and the output slot.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    resolve_d  = 1'b0;
    dout_d     = dout_q;
    valid_d    = valid_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d   = DATA;
            cnt_d     = '0;
            par_bad_d = 1'b0;
          end
        end
        DATA: begin
          shreg_d = {serial_in, shreg_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_bad_d = serial_in ^ par_exp;
          state_d   = STOP;
        end
        STOP: begin
          stop_bad_d = !serial_in;
          resolve_d  = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    ferr_d = resolve_q && stop_bad_q;
    perr_d = resolve_q && !stop_bad_q && par_bad_q;
    ovr_d  = good && valid_q && !data_ready;

    if (load) begin
      dout_d  = shreg_q;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      resolve_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      resolve_q  <= resolve_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed tests for serial_frame_rx
// (8 data bits, even parity).
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       bit_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int pass_cnt = 0;
  int total = 0;

  serial_frame_rx #(
    .DATA_W(8),
    .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .bit_en(bit_en),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic b, input int gap, input bit tog);
    serial_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    repeat (gap - 1) begin
      if (tog) serial_in = ~serial_in;
      tick();
    end
  endtask

  // Sends start, 8 data bits LSB first, parity, stop; returns just after
  // the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 10; i++) send_one(f[i], 4, 1'b0);
    send_one(f[10], 1, 1'b0);
    serial_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_in = 1'b0;
    bit_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bit_en = 1'b0;
    serial_in = 1'b1;
    total++;
    if (data_out !== 8'h00) $display("FAIL reset_data got %h want 00", data_out);
    else pass_cnt++;
    total++;
    if (data_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", data_valid);
    else pass_cnt++;
    total++;
    if ({parity_err, frame_err, overrun} !== 3'b000)
      $display("FAIL reset_errs got %b want 000", {parity_err, frame_err, overrun});
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int bad;
    send_frame(8'hA5, 1'b0, 1'b1);
    total++;
    if (data_valid !== 1'b0) $display("FAIL basic_latency got %b want 0", data_valid);
    else pass_cnt++;
    tick();
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5)
      $display("FAIL basic_rx got v=%b d=%h want v=1 d=a5", data_valid, data_out);
    else pass_cnt++;
    total++;
    if ({parity_err, frame_err, overrun} !== 3'b000)
      $display("FAIL basic_errs got %b want 000", {parity_err, frame_err, overrun});
    else pass_cnt++;
    bad = 0;
    repeat (5) begin
      tick();
      if (data_valid !== 1'b1 || data_out !== 8'hA5) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL basic_hold got %0d unstable cycles want 0", bad);
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    total++;
    if (data_valid !== 1'b0) $display("FAIL basic_accept got %b want 0", data_valid);
    else pass_cnt++;
  endtask

  task automatic test_parity_err();
    send_frame(8'hA5, 1'b1, 1'b1);
    tick();
    total++;
    if ({parity_err, frame_err, overrun} !== 3'b100)
      $display("FAIL par_pulse got %b want 100", {parity_err, frame_err, overrun});
    else pass_cnt++;
    total++;
    if (data_valid !== 1'b0) $display("FAIL par_valid got %b want 0", data_valid);
    else pass_cnt++;
    tick();
    total++;
    if (parity_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL par_after got perr=%b busy=%b want 0 0", parity_err, busy);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick();
    total++;
    if ({parity_err, frame_err, overrun} !== 3'b010)
      $display("FAIL ferr_pulse got %b want 010", {parity_err, frame_err, overrun});
    else pass_cnt++;
    total++;
    if (data_valid !== 1'b0) $display("FAIL ferr_valid got %b want 0", data_valid);
    else pass_cnt++;
    tick();
    total++;
    if (frame_err !== 1'b0) $display("FAIL ferr_width got %b want 0", frame_err);
    else pass_cnt++;
    send_frame(8'h81, 1'b0, 1'b1);
    tick();
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'h81)
      $display("FAIL ferr_next got v=%b d=%h want v=1 d=81", data_valid, data_out);
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b0, 1'b1);
    tick();
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'h11)
      $display("FAIL b2b_first got v=%b d=%h want v=1 d=11", data_valid, data_out);
    else pass_cnt++;
    send_frame(8'h22, 1'b0, 1'b1);
    tick();
    total++;
    if (overrun !== 1'b1 || data_out !== 8'h11 || data_valid !== 1'b1)
      $display("FAIL b2b_overrun got o=%b d=%h v=%b want o=1 d=11 v=1",
               overrun, data_out, data_valid);
    else pass_cnt++;
    tick();
    total++;
    if (overrun !== 1'b0) $display("FAIL b2b_ovr_width got %b want 0", overrun);
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    total++;
    if (data_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", data_valid);
    else pass_cnt++;

    send_frame(8'h11, 1'b0, 1'b1);
    tick();
    send_frame(8'h22, 1'b0, 1'b1);
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'h11)
      $display("FAIL b2b_pre got v=%b d=%h want v=1 d=11", data_valid, data_out);
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'h22 || overrun !== 1'b0)
      $display("FAIL b2b_swap got v=%b d=%h o=%b want v=1 d=22 o=0",
               data_valid, data_out, overrun);
    else pass_cnt++;
    tick();
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'h22)
      $display("FAIL b2b_keep got v=%b d=%h want v=1 d=22", data_valid, data_out);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [4:0] part;
    part = 5'b00000;
    for (int i = 0; i < 5; i++) send_one(part[i], 4, 1'b0);
    total++;
    if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    serial_in = 1'b0;
    bit_en = 1'b1;
    tick();
    rst = 1'b0;
    bit_en = 1'b0;
    serial_in = 1'b1;
    total++;
    if ({data_out, data_valid, parity_err, frame_err, overrun, busy} !== 13'h0)
      $display("FAIL mid_clear got d=%h v=%b p=%b f=%b o=%b b=%b want all 0",
               data_out, data_valid, parity_err, frame_err, overrun, busy);
    else pass_cnt++;
    tick();
    send_frame(8'h5A, 1'b0, 1'b1);
    tick();
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'h5A)
      $display("FAIL mid_next got v=%b d=%h want v=1 d=5a", data_valid, data_out);
    else pass_cnt++;
    total++;
    if ({parity_err, frame_err, overrun} !== 3'b000)
      $display("FAIL mid_errs got %b want 000", {parity_err, frame_err, overrun});
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_gating();
    int gaps [11] = '{1, 7, 3, 2, 5, 1, 6, 4, 2, 3, 1};
    logic [10:0] f;
    f = {1'b1, 1'b0, 8'hC3, 1'b0};
    for (int i = 0; i < 11; i++) send_one(f[i], gaps[i], 1'b1);
    serial_in = 1'b1;
    tick();
    total++;
    if (data_valid !== 1'b1 || data_out !== 8'hC3)
      $display("FAIL gate_rx got v=%b d=%h want v=1 d=c3", data_valid, data_out);
    else pass_cnt++;
    total++;
    if ({parity_err, frame_err, overrun} !== 3'b000)
      $display("FAIL gate_errs got %b want 000", {parity_err, frame_err, overrun});
    else pass_cnt++;
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_gating();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
